// File: rtl/urv_dpram_pkg.sv
// Shared types and helpers for the uRV dual-port RAM: clear-sequencer state
// encoding and a constant-foldable ceiling-log2.
package urv_dpram_pkg;

    typedef enum logic {
        CLR_CLEAR = 1'b0,
        CLR_READY = 1'b1
    } clr_state_e;

    function automatic int urv_clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/urv_dpram_clear_ctl.sv
// Post-reset clear sequencer: walks every word index once, requesting a zero
// write on the array's port A, then raises ready_o.
module urv_dpram_clear_ctl
    import urv_dpram_pkg::*;
#(
    parameter int g_depth          = 16384,
    parameter int g_clear_on_reset = 1,
    localparam int IW              = urv_clog2(g_depth)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic          ready_o,
    output logic          clr_we_o,
    output logic [IW-1:0] clr_idx_o
);

    localparam logic [IW-1:0] LAST_IDX = IW'(g_depth - 1);

    clr_state_e    state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic          ready_q, ready_d;

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_we_o = 1'b0;
        ready_d  = (state_q == CLR_READY);
        case (state_q)
            CLR_CLEAR: begin
                clr_we_o = 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = CLR_READY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CLR_READY: begin
                state_d = CLR_READY;
            end
            default: begin
                state_d = CLR_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= (g_clear_on_reset != 0) ? CLR_CLEAR : CLR_READY;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    assign ready_o   = ready_q;
    assign clr_idx_o = cnt_q;

endmodule

// File: rtl/urv_dpram.sv
// True dual-port byte-writable RAM for the uRV memory subsystem: port A wins
// overlapping same-word writes, cross-port reads see old data.
module urv_dpram
    import urv_dpram_pkg::*;
#(
    parameter int g_data_width     = 32,
    parameter int g_depth          = 16384,
    parameter int g_output_reg     = 0,
    parameter int g_clear_on_reset = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    output logic                      ready_o,
    input  logic                      ena_i,
    input  logic                      wea_i,
    input  logic [31:0]               aa_i,
    input  logic [g_data_width/8-1:0] bwea_i,
    input  logic [g_data_width-1:0]   da_i,
    output logic [g_data_width-1:0]   qa_o,
    input  logic                      enb_i,
    input  logic                      web_i,
    input  logic [31:0]               ab_i,
    input  logic [g_data_width/8-1:0] bweb_i,
    input  logic [g_data_width-1:0]   db_i,
    output logic [g_data_width-1:0]   qb_o,
    output logic                      collision_o
);

    localparam int NL = g_data_width / 8;
    localparam int LB = urv_clog2(NL);
    localparam int IW = urv_clog2(g_depth);

    logic                    ready;
    logic                    clr_we;
    logic [IW-1:0]           clr_idx;
    logic [IW-1:0]           idx_a, idx_b;
    logic                    port_ok, rd_en_a, rd_en_b, wr_a, wr_b;
    logic                    ma_we;
    logic [IW-1:0]           ma_idx;
    logic [NL-1:0]           ma_strb;
    logic [g_data_width-1:0] ma_data;
    logic [g_data_width-1:0] rd_a_d, rd_b_d;
    logic [g_data_width-1:0] q1a_q, q1b_q;
    logic                    coll_q, coll_d;
    logic                    unused_addr;

    // NOTE: the array has no reset; the clear sequencer zeroes it instead.
    logic [g_data_width-1:0] mem_q [g_depth];

    urv_dpram_clear_ctl #(
        .g_depth          (g_depth),
        .g_clear_on_reset (g_clear_on_reset)
    ) u_clear_ctl (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .ready_o   (ready),
        .clr_we_o  (clr_we),
        .clr_idx_o (clr_idx)
    );

    // Bits outside the word index are deliberately don't-care.
    assign unused_addr = ^{aa_i, ab_i};
    assign idx_a       = aa_i[IW+LB-1:LB];
    assign idx_b       = ab_i[IW+LB-1:LB];

    assign port_ok = ready & ~rst_i;
    assign rd_en_a = port_ok & ena_i;
    assign rd_en_b = port_ok & enb_i;
    assign wr_a    = rd_en_a & wea_i;
    assign wr_b    = rd_en_b & web_i;
    assign coll_d  = wr_a & wr_b & (idx_a == idx_b) & (|(bwea_i & bweb_i));

    always_comb begin
        ma_we   = wr_a;
        ma_idx  = idx_a;
        ma_strb = bwea_i;
        ma_data = da_i;
        if (clr_we) begin
            ma_we   = 1'b1;
            ma_idx  = clr_idx;
            ma_strb = '1;
            ma_data = '0;
        end
    end

    // NOTE: non-blocking writes keep this edge's reads on old data; A's lanes
    // are assigned last, so A wins on overlapping lanes of the same word.
    always_ff @(posedge clk_i) begin
        for (int l = 0; l < NL; l++) begin
            if (wr_b && bweb_i[l]) begin
                mem_q[idx_b][8*l +: 8] <= db_i[8*l +: 8];
            end
            if (ma_we && ma_strb[l]) begin
                mem_q[ma_idx][8*l +: 8] <= ma_data[8*l +: 8];
            end
        end
    end

    // Each port sees its own strobed lanes as new data, never the other port's.
    always_comb begin
        rd_a_d = mem_q[idx_a];
        rd_b_d = mem_q[idx_b];
        for (int l = 0; l < NL; l++) begin
            if (wr_a && bwea_i[l]) begin
                rd_a_d[8*l +: 8] = da_i[8*l +: 8];
            end
            if (wr_b && bweb_i[l]) begin
                rd_b_d[8*l +: 8] = db_i[8*l +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q1a_q  <= '0;
            q1b_q  <= '0;
            coll_q <= 1'b0;
        end else begin
            if (rd_en_a) begin
                q1a_q <= rd_a_d;
            end
            if (rd_en_b) begin
                q1b_q <= rd_b_d;
            end
            coll_q <= coll_d;
        end
    end

    if (g_output_reg != 0) begin : g_out_reg
        logic                    v1a_q, v1b_q;
        logic [g_data_width-1:0] q2a_q, q2b_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                v1a_q <= 1'b0;
                v1b_q <= 1'b0;
                q2a_q <= '0;
                q2b_q <= '0;
            end else begin
                v1a_q <= rd_en_a;
                v1b_q <= rd_en_b;
                if (v1a_q) begin
                    q2a_q <= q1a_q;
                end
                if (v1b_q) begin
                    q2b_q <= q1b_q;
                end
            end
        end

        assign qa_o = q2a_q;
        assign qb_o = q2b_q;
    end else begin : g_out_direct
        assign qa_o = q1a_q;
        assign qb_o = q1b_q;
    end

    assign ready_o     = ready;
    assign collision_o = coll_q;

endmodule

// File: tb/tb_urv_dpram.sv
// Self-checking bench for urv_dpram: two instances (1- and 2-cycle latency)
// driven in lockstep and compared every cycle against a word-array model.
module tb_urv_dpram;

    localparam int DEPTH     = 16;
    localparam int CLEAR_LAT = DEPTH + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena, enb, wea, web;
    logic [31:0] aa, ab, da, db;
    logic [3:0]  bwea, bweb;
    logic        ready0, ready1, col0, col1;
    logic [31:0] qa0, qb0, qa1, qb1;

    always #5 clk = ~clk;

    urv_dpram #(
        .g_data_width(32), .g_depth(DEPTH), .g_output_reg(0), .g_clear_on_reset(1)
    ) dut0 (
        .clk_i(clk), .rst_i(rst), .ready_o(ready0),
        .ena_i(ena), .wea_i(wea), .aa_i(aa), .bwea_i(bwea), .da_i(da), .qa_o(qa0),
        .enb_i(enb), .web_i(web), .ab_i(ab), .bweb_i(bweb), .db_i(db), .qb_o(qb0),
        .collision_o(col0)
    );

    urv_dpram #(
        .g_data_width(32), .g_depth(DEPTH), .g_output_reg(1), .g_clear_on_reset(1)
    ) dut1 (
        .clk_i(clk), .rst_i(rst), .ready_o(ready1),
        .ena_i(ena), .wea_i(wea), .aa_i(aa), .bwea_i(bwea), .da_i(da), .qa_o(qa1),
        .enb_i(enb), .web_i(web), .ab_i(ab), .bweb_i(bweb), .db_i(db), .qb_o(qb1),
        .collision_o(col1)
    );

    // Model: word array, cycles since reset, and a history of completed reads.
    typedef struct {
        int          edge_no;
        logic [31:0] val;
    } rd_t;
    typedef rd_t rdq_t[$];

    logic [31:0] mem_m [DEPTH];
    rdq_t        hist_a, hist_b;
    int          edge_no = 0;
    int          since   = 0;
    logic        exp_col = 1'b0;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Value a port shows with latency lat: latest read sampled lat-1 or more edges ago.
    function automatic logic [31:0] lookup(input rdq_t q, input int lat);
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].edge_no <= edge_no - (lat - 1)) begin
                return q[i].val;
            end
        end
        return 32'h0;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int l = 0; l < 4; l++) begin
            if (strb[l]) begin
                r[8*l +: 8] = new_w[8*l +: 8];
            end
        end
        return r;
    endfunction

    // One clock: update the model from the driven inputs, clock, then compare everything.
    task automatic step();
        int          ia, ib;
        logic        ok, wa, wb;
        logic [31:0] va, vb;
        rd_t         e;
        ia = int'(aa[5:2]);
        ib = int'(ab[5:2]);
        ok = (since >= CLEAR_LAT) && !rst;
        wa = ok && ena && wea;
        wb = ok && enb && web;
        if (rst) begin
            foreach (mem_m[i]) mem_m[i] = 32'h0;
            hist_a.delete();
            hist_b.delete();
            since   = 0;
            exp_col = 1'b0;
        end else begin
            va = merge(mem_m[ia], da, wa ? bwea : 4'h0);
            vb = merge(mem_m[ib], db, wb ? bweb : 4'h0);
            if (ok && ena) begin
                e.edge_no = edge_no + 1;
                e.val     = va;
                hist_a.push_back(e);
            end
            if (ok && enb) begin
                e.edge_no = edge_no + 1;
                e.val     = vb;
                hist_b.push_back(e);
            end
            exp_col = wa && wb && (ia == ib) && ((bwea & bweb) != 4'h0);
            if (wb) mem_m[ib] = merge(mem_m[ib], db, bweb);
            if (wa) mem_m[ia] = merge(mem_m[ia], da, bwea);
            since++;
        end
        @(posedge clk);
        edge_no++;
        #1;
        check("ready0", {31'b0, ready0}, {31'b0, since >= CLEAR_LAT});
        check("ready1", {31'b0, ready1}, {31'b0, since >= CLEAR_LAT});
        check("col0", {31'b0, col0}, {31'b0, exp_col});
        check("col1", {31'b0, col1}, {31'b0, exp_col});
        check("qa0", qa0, lookup(hist_a, 1));
        check("qb0", qb0, lookup(hist_b, 1));
        check("qa1", qa1, lookup(hist_a, 2));
        check("qb1", qb1, lookup(hist_b, 2));
        @(negedge clk);
    endtask

    task automatic idle();
        ena = 1'b0; wea = 1'b0; bwea = 4'h0;
        enb = 1'b0; web = 1'b0; bweb = 4'h0;
    endtask

    task automatic op_a(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] data);
        ena = 1'b1; wea = we; aa = addr; bwea = strb; da = data;
    endtask

    task automatic op_b(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] data);
        enb = 1'b1; web = we; ab = addr; bweb = strb; db = data;
    endtask

    // Clock with current inputs until ready rises; the count of cycles is checked.
    task automatic wait_ready(input string tag);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!ready0 && k < 100);
        check(tag, k, CLEAR_LAT);
    endtask

    task automatic rand_ops();
        ena  = 1'($urandom_range(0, 1));
        enb  = 1'($urandom_range(0, 1));
        wea  = 1'($urandom_range(0, 1));
        web  = 1'($urandom_range(0, 1));
        bwea = 4'($urandom);
        bweb = 4'($urandom);
        da   = $urandom;
        db   = $urandom;
        aa   = $urandom;
        ab   = ($urandom_range(0, 2) == 0) ? (aa ^ ($urandom & 32'hFFFF_FFC3)) : $urandom;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        aa = '0; ab = '0; da = '0; db = '0;
        @(negedge clk);
        repeat (3) step();
        rst = 1'b0;
        wait_ready("init_ready_lat");

        // Pre-fill with all-ones, then reset and confirm the clear wipes it.
        for (int i = 0; i < DEPTH; i++) begin
            op_a(1'b1, 32'(i * 4), 4'hF, 32'hFFFF_FFFF);
            step();
        end
        idle();
        op_b(1'b0, 32'h1C, 4'h0, 32'h0);
        step();
        check("prefill_rd", qb0, 32'hFFFF_FFFF);
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_ready("clear_ready_lat");
        for (int i = 0; i < DEPTH; i++) begin
            op_a(1'b0, 32'(i * 4), 4'h0, 32'h0);
            op_b(1'b0, 32'((DEPTH - 1 - i) * 4), 4'h0, 32'h0);
            step();
            check("clear_rd_a", qa0, 32'h0);
            check("clear_rd_b", qb0, 32'h0);
        end
        idle();
        step();

        // Byte strobes; address 0x40 wraps onto word 0 with 16 words.
        op_a(1'b1, 32'h40, 4'hF, 32'h1122_3344);
        step();
        op_a(1'b1, 32'h40, 4'h5, 32'hDEAD_BEEF);
        step();
        op_a(1'b0, 32'h00, 4'h0, 32'h0);
        step();
        check("strobe_lat1", qa0, 32'h11AD_33EF);
        idle();
        step();
        check("strobe_lat2", qa1, 32'h11AD_33EF);
        check("hold_lat1", qa0, 32'h11AD_33EF);

        // Overlapping same-word writes: A wins lane 1, collision pulses once.
        op_a(1'b1, 32'h14, 4'h3, 32'hAAAA_AAAA);
        op_b(1'b1, 32'h14, 4'h6, 32'hBBBB_BBBB);
        step();
        check("col_pulse", {31'b0, col0}, 32'h1);
        idle();
        op_a(1'b0, 32'h14, 4'h0, 32'h0);
        step();
        check("col_gone", {31'b0, col0}, 32'h0);
        check("col_word", qa0, 32'h00BB_AAAA);
        idle();

        // Cross-port read during write sees the old word.
        op_a(1'b1, 32'h0C, 4'hF, 32'h1234_5678);
        op_b(1'b0, 32'h0C, 4'h0, 32'h0);
        step();
        check("mixed_old", qb0, 32'h0);
        idle();
        op_b(1'b0, 32'h0C, 4'h0, 32'h0);
        step();
        check("mixed_new", qb0, 32'h1234_5678);

        repeat (400) begin
            rand_ops();
            step();
        end
        idle();

        // Reset again at clear count 7; writes during the clear must be dropped.
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (7) begin
            rand_ops();
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        op_a(1'b1, 32'h20, 4'hF, 32'hCAFE_F00D);
        op_b(1'b1, 32'h24, 4'hF, 32'h0BAD_CAFE);
        wait_ready("restart_ready_lat");
        idle();
        op_a(1'b0, 32'h20, 4'h0, 32'h0);
        op_b(1'b0, 32'h24, 4'h0, 32'h0);
        step();
        check("clear_drop_a", qa0, 32'h0);
        check("clear_drop_b", qb0, 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            op_a(1'b0, 32'(i * 4), 4'h0, 32'h0);
            step();
        end
        idle();
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
